// File: rtl/branch_predictor.sv
// Direct-mapped, tagged branch history table with 2-bit saturating counters.
// Supplies a combinational taken/not-taken guess for the branch in decode and
// trains on branches resolved in execute. Also counts resolved and correctly
// predicted branches for CSR/debug readout.
module branch_predictor #(
   parameter int unsigned N_ENTRIES = 32,
   parameter int unsigned TAG_BITS  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] guess_pc,
   input  logic        guess_valid,
   output logic        guess_taken,
   input  logic [31:0] check_pc,
   input  logic        check_valid,
   input  logic        check_taken,
   input  logic        check_pred,
   output logic [31:0] br_count,
   output logic [31:0] br_correct
);

   localparam int unsigned IDX_BITS = $clog2(N_ENTRIES);

   // PC bits that take part in indexing or tagging; the rest are don't-care
   localparam logic [31:0] USED_MASK = ((32'h1 << (IDX_BITS + TAG_BITS)) - 32'h1) << 2;

   localparam logic [1:0] CTR_WEAK_NT = 2'b01;
   localparam logic [1:0] CTR_WEAK_T  = 2'b10;

   logic [N_ENTRIES-1:0] valid_q;
   logic [TAG_BITS-1:0]  tag_q [N_ENTRIES];
   logic [1:0]           ctr_q [N_ENTRIES];

   logic [IDX_BITS-1:0]  guess_idx;
   logic [TAG_BITS-1:0]  guess_tag;
   logic [IDX_BITS-1:0]  check_idx;
   logic [TAG_BITS-1:0]  check_tag;
   logic                 check_hit;
   logic                 unused_pc_bits;

   assign guess_idx = guess_pc[IDX_BITS+1:2];
   assign guess_tag = guess_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
   assign check_idx = check_pc[IDX_BITS+1:2];
   assign check_tag = check_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

   assign unused_pc_bits = ^{guess_pc & ~USED_MASK, check_pc & ~USED_MASK};

   // Lookup: reads only the current table registers, never the check_* inputs
   always_comb begin
      guess_taken = 1'b0;
      if (guess_valid && valid_q[guess_idx] && (tag_q[guess_idx] == guess_tag)) begin
         guess_taken = ctr_q[guess_idx][1];
      end
   end

   assign check_hit = valid_q[check_idx] && (tag_q[check_idx] == check_tag);

   // Table training: saturating step on hit, weak-state allocation on miss
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            tag_q[i] <= '0;
            ctr_q[i] <= CTR_WEAK_NT;
         end
      end else if (check_valid) begin
         if (check_hit) begin
            if (check_taken) begin
               if (ctr_q[check_idx] != 2'b11) begin
                  ctr_q[check_idx] <= ctr_q[check_idx] + 2'd1;
               end
            end else begin
               if (ctr_q[check_idx] != 2'b00) begin
                  ctr_q[check_idx] <= ctr_q[check_idx] - 2'd1;
               end
            end
         end else begin
            valid_q[check_idx] <= 1'b1;
            tag_q[check_idx]   <= check_tag;
            ctr_q[check_idx]   <= check_taken ? CTR_WEAK_T : CTR_WEAK_NT;
         end
      end
   end

   // Statistics: resolved branches and correct predictions, wrapping mod 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         br_count   <= '0;
         br_correct <= '0;
      end else if (check_valid) begin
         br_count <= br_count + 32'd1;
         if (check_pred == check_taken) begin
            br_correct <= br_correct + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed
// expectations (N_ENTRIES=32, TAG_BITS=8: idx = pc[6:2], tag = pc[14:7]).
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] guess_pc;
   logic        guess_valid;
   logic        guess_taken;
   logic [31:0] check_pc;
   logic        check_valid;
   logic        check_taken;
   logic        check_pred;
   logic [31:0] br_count;
   logic [31:0] br_correct;

   int total;
   int bad;

   branch_predictor #(
      .N_ENTRIES(32),
      .TAG_BITS (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .guess_pc   (guess_pc),
      .guess_valid(guess_valid),
      .guess_taken(guess_taken),
      .check_pc   (check_pc),
      .check_valid(check_valid),
      .check_taken(check_taken),
      .check_pred (check_pred),
      .br_count   (br_count),
      .br_correct (br_correct)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // advance past the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken, input logic pred);
      check_pc    = pc;
      check_taken = taken;
      check_pred  = pred;
      check_valid = 1'b1;
      step();
      check_valid = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc, output logic g);
      guess_pc    = pc;
      guess_valid = 1'b1;
      #1;
      g = guess_taken;
   endtask

   logic g;

   initial begin
      total       = 0;
      bad         = 0;
      rst         = 1'b1;
      guess_pc    = 32'h40;
      guess_valid = 1'b1;
      check_pc    = '0;
      check_valid = 1'b0;
      check_taken = 1'b0;
      check_pred  = 1'b0;

      // reset
      step();
      step();
      #1;
      chk("rst_guess", {31'd0, guess_taken}, 32'd0);
      rst = 1'b0;
      look(32'h40, g);
      chk("post_rst_guess", {31'd0, g}, 32'd0);
      chk("rst_count", br_count, 32'd0);
      chk("rst_correct", br_correct, 32'd0);

      // allocate and train
      upd(32'h40, 1'b1, 1'b0);                       // alloc ctr=10
      look(32'h40, g);
      chk("alloc_guess", {31'd0, g}, 32'd1);
      chk("alloc_count", br_count, 32'd1);
      chk("alloc_correct", br_correct, 32'd0);
      look(32'h43, g);                               // low pc bits ignored
      chk("lowbits_guess", {31'd0, g}, 32'd1);
      guess_valid = 1'b0;
      #1;
      chk("gvalid0_guess", {31'd0, guess_taken}, 32'd0);
      upd(32'h40, 1'b1, 1'b1);                       // 11
      upd(32'h40, 1'b1, 1'b1);                       // 11 saturated
      upd(32'h40, 1'b0, 1'b1);                       // 10
      look(32'h40, g);
      chk("sat_then_nt1", {31'd0, g}, 32'd1);
      upd(32'h40, 1'b0, 1'b1);                       // 01
      look(32'h40, g);
      chk("nt2_guess", {31'd0, g}, 32'd0);
      upd(32'h40, 1'b0, 1'b1);                       // 00
      look(32'h40, g);
      chk("nt3_guess", {31'd0, g}, 32'd0);
      chk("train_count", br_count, 32'd6);
      chk("train_correct", br_correct, 32'd2);

      // tag conflict at idx 16
      upd(32'h40, 1'b1, 1'b0);                       // 01
      upd(32'h40, 1'b1, 1'b0);                       // 10
      look(32'h40, g);
      chk("retrain_guess", {31'd0, g}, 32'd1);
      upd(32'hC0, 1'b0, 1'b0);                       // evict, ctr=01
      look(32'h40, g);
      chk("evicted_guess", {31'd0, g}, 32'd0);
      look(32'hC0, g);
      chk("alias_weak_nt", {31'd0, g}, 32'd0);
      upd(32'hC0, 1'b1, 1'b0);                       // hit, 10
      look(32'hC0, g);
      chk("alias_taken", {31'd0, g}, 32'd1);
      look(32'h40, g);
      chk("alias_old_miss", {31'd0, g}, 32'd0);
      chk("alias_count", br_count, 32'd10);
      chk("alias_correct", br_correct, 32'd3);

      // same-cycle read/write: lookup sees pre-update entry
      upd(32'h40, 1'b1, 1'b0);                       // realloc ctr=10
      guess_pc    = 32'h40;
      guess_valid = 1'b1;
      check_pc    = 32'h40;
      check_taken = 1'b0;
      check_pred  = 1'b1;
      check_valid = 1'b1;
      #1;
      chk("same_cycle_old", {31'd0, guess_taken}, 32'd1);
      step();
      check_valid = 1'b0;
      look(32'h40, g);
      chk("same_cycle_new", {31'd0, g}, 32'd0);
      chk("same_count", br_count, 32'd12);
      chk("same_correct", br_correct, 32'd3);

      // statistics from a clean start
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst2_count", br_count, 32'd0);
      for (int i = 0; i < 10; i++) begin
         logic t;
         t = (i % 2) == 1;
         upd(32'h100 + 32'(i) * 32'd4, t, (i < 7) ? t : ~t);
      end
      chk("stat_count", br_count, 32'd10);
      chk("stat_correct", br_correct, 32'd7);
      look(32'h104, g);
      chk("stat_entry_t", {31'd0, g}, 32'd1);
      look(32'h100, g);
      chk("stat_entry_nt", {31'd0, g}, 32'd0);
      guess_valid = 1'b0;
      check_pc    = 32'h200;
      check_taken = 1'b1;
      check_pred  = 1'b1;
      check_valid = 1'b0;
      step();
      chk("idle_count", br_count, 32'd10);
      chk("idle_correct", br_correct, 32'd7);
      look(32'h200, g);
      chk("idle_no_alloc", {31'd0, g}, 32'd0);

      // reset mid-stream with a concurrent update
      rst         = 1'b1;
      check_pc    = 32'h104;
      check_taken = 1'b1;
      check_pred  = 1'b1;
      check_valid = 1'b1;
      step();
      rst         = 1'b0;
      check_valid = 1'b0;
      look(32'h104, g);
      chk("midrst_guess", {31'd0, g}, 32'd0);
      chk("midrst_count", br_count, 32'd0);
      chk("midrst_correct", br_correct, 32'd0);
      upd(32'h104, 1'b1, 1'b1);
      look(32'h104, g);
      chk("post_midrst_guess", {31'd0, g}, 32'd1);
      chk("post_midrst_count", br_count, 32'd1);
      chk("post_midrst_correct", br_correct, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
